atm_auth_responder: RTL and testbench

//  Bank-side authorization responder serving ATM controller requests.

---
 rtl/atm_auth_responder_if.sv | 34 +++
 rtl/atm_auth_responder.sv | 166 ++++++++++++++++
 tb/tb_atm_auth_responder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/atm_auth_responder_if.sv
// Request/response and host-configuration channels of the ATM authorization responder.
// The master modport is the ATM controller/host side; the slave modport is the responder.
interface atm_auth_responder_if #(
  parameter int ACCT_W = 2,
  parameter int PIN_W  = 16,
  parameter int BAL_W  = 16
);
  logic              req_valid;
  logic              req_ready;
  logic              req_op;
  logic [ACCT_W-1:0] req_acct;
  logic [PIN_W-1:0]  req_pin;
  logic [BAL_W-1:0]  req_amt;
  logic              resp_valid;
  logic              resp_ready;
  logic [1:0]        resp_code;
  logic [BAL_W-1:0]  resp_bal;
  logic              cfg_we;
  logic [ACCT_W-1:0] cfg_acct;
  logic [PIN_W-1:0]  cfg_pin;
  logic [BAL_W-1:0]  cfg_bal;

  modport master (
    output req_valid, req_op, req_acct, req_pin, req_amt, resp_ready,
           cfg_we, cfg_acct, cfg_pin, cfg_bal,
    input  req_ready, resp_valid, resp_code, resp_bal
  );

  modport slave (
    input  req_valid, req_op, req_acct, req_pin, req_amt, resp_ready,
           cfg_we, cfg_acct, cfg_pin, cfg_bal,
    output req_ready, resp_valid, resp_code, resp_bal
  );
endinterface

// File: rtl/atm_auth_responder.sv
// Bank-side authorization responder: per-account PIN/balance/retry/lock table
// answering PIN-check and withdrawal requests after a fixed lookup latency.
module atm_auth_responder #(
  parameter int NUM_ACCTS = 4,
  parameter int ACCT_W    = 2,
  parameter int PIN_W     = 16,
  parameter int BAL_W     = 16,
  parameter int MAX_TRIES = 3,
  parameter int LAT       = 2
) (
  input logic                clk,
  input logic                rst_n,
  atm_auth_responder_if.slave bus
);

  localparam int TRY_W = $clog2(MAX_TRIES + 1);
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [1:0] CODE_OK       = 2'b00;
  localparam logic [1:0] CODE_BAD_PIN  = 2'b01;
  localparam logic [1:0] CODE_NO_FUNDS = 2'b10;
  localparam logic [1:0] CODE_LOCKED   = 2'b11;

  typedef enum logic [1:0] {IDLE, LOOKUP, RESPOND} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               req_ready;
  logic               resp_valid;
  logic [1:0]         resp_code;
  logic [BAL_W-1:0]   resp_bal;

  logic               op_p0;
  logic [ACCT_W-1:0]  acct_p0;
  logic [PIN_W-1:0]   pin_p0;
  logic [BAL_W-1:0]   amt_p0;

  logic [PIN_W-1:0]   pin_tbl   [NUM_ACCTS];
  logic [BAL_W-1:0]   bal_tbl   [NUM_ACCTS];
  logic [TRY_W-1:0]   tries_tbl [NUM_ACCTS];
  logic               lock_tbl  [NUM_ACCTS];

  logic               accept;
  logic               eval_fire;
  logic [1:0]         ev_code;
  logic [BAL_W-1:0]   ev_bal;
  logic [BAL_W-1:0]   nx_bal;
  logic [TRY_W-1:0]   nx_tries;
  logic               nx_lock;
  logic [TRY_W-1:0]   tries_inc;

  assign bus.req_ready  = req_ready;
  assign bus.resp_valid = resp_valid;
  assign bus.resp_code  = resp_code;
  assign bus.resp_bal   = resp_bal;

  assign accept    = (state == IDLE) && bus.req_valid && req_ready;
  assign eval_fire = (state == LOOKUP) && (cnt == CNT_W'(LAT - 1));

  // Stage p0: request fields captured on acceptance, held through LOOKUP
  always_ff @(posedge clk) begin
    if (accept) begin
      op_p0   <= bus.req_op;
      acct_p0 <= bus.req_acct;
      pin_p0  <= bus.req_pin;
      amt_p0  <= bus.req_amt;
    end
  end

  // Evaluation: first matching rule wins
  always_comb begin
    ev_code   = CODE_OK;
    ev_bal    = '0;
    nx_bal    = bal_tbl[acct_p0];
    nx_tries  = tries_tbl[acct_p0];
    nx_lock   = lock_tbl[acct_p0];
    tries_inc = tries_tbl[acct_p0] + TRY_W'(1);
    if (lock_tbl[acct_p0]) begin
      ev_code = CODE_LOCKED;
    end else if (pin_p0 != pin_tbl[acct_p0]) begin
      ev_code = CODE_BAD_PIN;
      if (tries_inc == TRY_W'(MAX_TRIES)) begin
        nx_lock  = 1'b1;
        nx_tries = '0;
      end else begin
        nx_tries = tries_inc;
      end
    end else if (!op_p0) begin
      nx_tries = '0;
      ev_bal   = bal_tbl[acct_p0];
    end else if (amt_p0 > bal_tbl[acct_p0]) begin
      ev_code  = CODE_NO_FUNDS;
      nx_tries = '0;
    end else begin
      nx_tries = '0;
      nx_bal   = bal_tbl[acct_p0] - amt_p0;
      ev_bal   = bal_tbl[acct_p0] - amt_p0;
    end
  end

  // Table: the config write comes last so it overrides an evaluation update to the same account
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACCTS; i++) begin
        pin_tbl[i]   <= '0;
        bal_tbl[i]   <= '0;
        tries_tbl[i] <= '0;
        lock_tbl[i]  <= 1'b0;
      end
    end else begin
      if (eval_fire) begin
        bal_tbl[acct_p0]   <= nx_bal;
        tries_tbl[acct_p0] <= nx_tries;
        lock_tbl[acct_p0]  <= nx_lock;
      end
      if (bus.cfg_we) begin
        pin_tbl[bus.cfg_acct]   <= bus.cfg_pin;
        bal_tbl[bus.cfg_acct]   <= bus.cfg_bal;
        tries_tbl[bus.cfg_acct] <= '0;
        lock_tbl[bus.cfg_acct]  <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_code  <= '0;
      resp_bal   <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            cnt       <= '0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (eval_fire) begin
            resp_valid <= 1'b1;
            resp_code  <= ev_code;
            resp_bal   <= ev_bal;
            state      <= RESPOND;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESPOND: begin
          if (bus.resp_ready) begin
            resp_valid <= 1'b0;
            resp_code  <= '0;
            resp_bal   <= '0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_atm_auth_responder.sv
// Directed bench for atm_auth_responder: configuration, PIN checks, withdrawals,
// lockout, response back-pressure, config/evaluation collision and reset mid-response.
module tb_atm_auth_responder;

  localparam logic [1:0] OK = 2'b00, BAD = 2'b01, NOF = 2'b10, LCK = 2'b11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  atm_auth_responder_if #(.ACCT_W(2), .PIN_W(16), .BAL_W(16)) bus ();

  atm_auth_responder #(
    .NUM_ACCTS(4), .ACCT_W(2), .PIN_W(16), .BAL_W(16), .MAX_TRIES(3), .LAT(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [1:0] acct, input logic [15:0] pin, input logic [15:0] bal);
    bus.cfg_we = 1'b1; bus.cfg_acct = acct; bus.cfg_pin = pin; bus.cfg_bal = bal;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic send_req(input string tag, input logic op, input logic [1:0] acct,
                          input logic [15:0] pin, input logic [15:0] amt);
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin tick(); n++; end
    chk({tag, "_ready_wait"}, {31'd0, bus.req_ready}, 32'd1);
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_acct = acct;
    bus.req_pin = pin; bus.req_amt = amt;
    tick();
    bus.req_valid = 1'b0;
    chk({tag, "_ready_drop"}, {31'd0, bus.req_ready}, 32'd0);
  endtask

  task automatic wait_resp(input string tag, input logic [1:0] code, input logic [15:0] bal);
    int n = 0;
    while (bus.resp_valid !== 1'b1 && n < 20) begin tick(); n++; end
    chk({tag, "_latency"}, n, 32'd2);
    chk({tag, "_code"}, {30'd0, bus.resp_code}, {30'd0, code});
    chk({tag, "_bal"}, {16'd0, bus.resp_bal}, {16'd0, bal});
  endtask

  task automatic finish_resp(input string tag);
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    chk({tag, "_valid_drop"}, {31'd0, bus.resp_valid}, 32'd0);
    chk({tag, "_ready_low"}, {31'd0, bus.req_ready}, 32'd0);
    tick();
    chk({tag, "_ready_back"}, {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic txn(input string tag, input logic op, input logic [1:0] acct,
                     input logic [15:0] pin, input logic [15:0] amt,
                     input logic [1:0] code, input logic [15:0] bal);
    send_req(tag, op, acct, pin, amt);
    wait_resp(tag, code, bal);
    finish_resp(tag);
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_op = 1'b0; bus.req_acct = '0;
    bus.req_pin = '0; bus.req_amt = '0; bus.resp_ready = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_acct = '0; bus.cfg_pin = '0; bus.cfg_bal = '0;

    // Reset values, then req_ready rises on the first edge after release
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_code", {30'd0, bus.resp_code}, 32'd0);
    chk("rst_resp_bal", {16'd0, bus.resp_bal}, 32'd0);
    #21 rst_n = 1'b1;
    chk("rel_req_ready_before_edge", {31'd0, bus.req_ready}, 32'd0);
    tick();
    chk("rel_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // T1
    cfg(2'd1, 16'h1234, 16'd500);
    txn("t1_pin_ok", 1'b0, 2'd1, 16'h1234, 16'd0, OK, 16'd500);

    // T2
    txn("t2_wd200", 1'b1, 2'd1, 16'h1234, 16'd200, OK, 16'd300);
    txn("t2_wd301", 1'b1, 2'd1, 16'h1234, 16'd301, NOF, 16'd0);
    txn("t2_bal_kept", 1'b0, 2'd1, 16'h1234, 16'd0, OK, 16'd300);
    txn("t2_wd0", 1'b1, 2'd1, 16'h1234, 16'd0, OK, 16'd300);
    txn("t2_wd_all", 1'b1, 2'd1, 16'h1234, 16'd300, OK, 16'd0);
    cfg(2'd1, 16'h1234, 16'd500);

    // T3
    txn("t3_bad1", 1'b0, 2'd1, 16'h0000, 16'd0, BAD, 16'd0);
    txn("t3_bad2", 1'b0, 2'd1, 16'h0000, 16'd0, BAD, 16'd0);
    txn("t3_bad3", 1'b0, 2'd1, 16'h0000, 16'd0, BAD, 16'd0);
    txn("t3_locked", 1'b0, 2'd1, 16'h1234, 16'd0, LCK, 16'd0);
    txn("t3_locked_wd", 1'b1, 2'd1, 16'h1234, 16'd10, LCK, 16'd0);
    cfg(2'd1, 16'h1234, 16'd777);
    txn("t3_unlocked", 1'b0, 2'd1, 16'h1234, 16'd0, OK, 16'd777);

    // A good PIN clears the retry count, so two more misses do not lock
    txn("tr_bad1", 1'b0, 2'd2, 16'h0001, 16'd0, BAD, 16'd0);
    txn("tr_bad2", 1'b0, 2'd2, 16'h0001, 16'd0, BAD, 16'd0);
    txn("tr_good", 1'b0, 2'd2, 16'h0000, 16'd0, OK, 16'd0);
    txn("tr_bad3", 1'b0, 2'd2, 16'h0001, 16'd0, BAD, 16'd0);
    txn("tr_bad4", 1'b0, 2'd2, 16'h0001, 16'd0, BAD, 16'd0);
    txn("tr_still_open", 1'b0, 2'd2, 16'h0000, 16'd0, OK, 16'd0);

    // T4: back-pressure on the response channel
    send_req("t4", 1'b1, 2'd1, 16'h1234, 16'd77);
    wait_resp("t4", OK, 16'd700);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", {31'd0, bus.resp_valid}, 32'd1);
      chk("t4_hold_code", {30'd0, bus.resp_code}, {30'd0, OK});
      chk("t4_hold_bal", {16'd0, bus.resp_bal}, 32'd700);
      chk("t4_hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    finish_resp("t4");

    // T5: config write lands on the evaluation edge (accept edge + 2)
    send_req("t5", 1'b1, 2'd1, 16'h1234, 16'd100);
    tick();
    bus.cfg_we = 1'b1; bus.cfg_acct = 2'd1; bus.cfg_pin = 16'h5555; bus.cfg_bal = 16'd1000;
    tick();
    bus.cfg_we = 1'b0;
    chk("t5_valid", {31'd0, bus.resp_valid}, 32'd1);
    chk("t5_code", {30'd0, bus.resp_code}, {30'd0, OK});
    chk("t5_bal", {16'd0, bus.resp_bal}, 32'd600);
    finish_resp("t5");
    txn("t5_old_pin", 1'b0, 2'd1, 16'h1234, 16'd0, BAD, 16'd0);
    txn("t5_cfg_kept", 1'b0, 2'd1, 16'h5555, 16'd0, OK, 16'd1000);

    // T6: reset while a response is pending
    send_req("t6", 1'b1, 2'd1, 16'h5555, 16'd1);
    wait_resp("t6", OK, 16'd999);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("t6_rst_code", {30'd0, bus.resp_code}, 32'd0);
    chk("t6_rst_bal", {16'd0, bus.resp_bal}, 32'd0);
    chk("t6_rst_ready", {31'd0, bus.req_ready}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    chk("t6_rel_ready", {31'd0, bus.req_ready}, 32'd1);
    txn("t6_acct1_cleared", 1'b0, 2'd1, 16'h0000, 16'd0, OK, 16'd0);
    txn("t6_acct3_cleared", 1'b0, 2'd3, 16'h0000, 16'd0, OK, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
